// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_LSL = 3'b101,
        OP_LSR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    // Bit positions inside ALUFlags {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_multicycle_if.sv
// Operand/result handshake bundle between the datapath and the ALU.
interface alu_multicycle_if #(parameter int WIDTH = 32) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic [3:0]       ALUFlags;

    // Datapath side: issues operands, consumes results
    modport master (
        output in_valid, a, b, ALUControl, out_ready,
        input  in_ready, out_valid, Result, ALUFlags
    );

    // ALU side
    modport slave (
        input  in_valid, a, b, ALUControl, out_ready,
        output in_ready, out_valid, Result, ALUFlags
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier, one multiplier bit per cycle, WIDTH iterations.
// Operands are captured on start; done pulses for one cycle once the
// counter has run out, with product holding the low WIDTH bits.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;

    // Capture operands on start, then add-and-shift until the counter empties
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            run    <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            cnt    <= CW'(WIDTH);
            run    <= 1'b1;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (run) begin
            if (cnt != '0) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end else begin
                run <= 1'b0;
            end
        end
    end

    assign done    = run & (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready in and out. Single-cycle ops land in the
// output register on the accept edge; mul runs in alu_mul_iter and lands
// one cycle after it finishes. A held result blocks new work unless the
// consumer drains it in the same cycle.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input logic              clk,
    input logic              reset_n,
    alu_multicycle_if.slave  bus
);

    localparam int SW = $clog2(WIDTH);

    state_e           state_q, state_d;
    alu_op_e          op;
    logic             in_ready;
    logic             accept;
    logic             is_mul;
    logic             mul_start, load_single, load_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    logic [SW-1:0]    shamt;
    logic [WIDTH:0]   sum_ext, diff_ext, lsl_ext, lsr_ext;
    logic [WIDTH-1:0] alu_res, ld_res;
    logic             alu_c, alu_v;
    logic [3:0]       ld_flags;

    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;

    assign op       = alu_op_e'(bus.ALUControl);
    assign is_mul   = (op == OP_MUL) && (MUL_EN != 0);
    assign in_ready = reset_n & ((state_q == IDLE) | ((state_q == HOLD) & bus.out_ready));
    assign accept   = bus.in_valid & in_ready;
    assign shamt    = bus.b[SW-1:0];

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: drain/finish first, then a new accept takes precedence
    always_comb begin
        state_d     = state_q;
        mul_start   = 1'b0;
        load_single = 1'b0;
        load_mul    = 1'b0;
        case (state_q)
            BUSY: begin
                if (mul_done) begin
                    state_d  = HOLD;
                    load_mul = 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
        if (accept) begin
            if (is_mul) begin
                state_d   = BUSY;
                mul_start = 1'b1;
            end else begin
                state_d     = HOLD;
                load_single = 1'b1;
            end
        end
    end

    // Single-cycle datapath; carries come from one extra MSB/LSB of the extended result
    always_comb begin
        sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
        diff_ext = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
        lsl_ext  = {1'b0, bus.a} << shamt;
        lsr_ext  = {bus.a, 1'b0} >> shamt;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (diff_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_LSL: begin
                alu_res = lsl_ext[WIDTH-1:0];
                alu_c   = lsl_ext[WIDTH];
            end
            OP_LSR: begin
                alu_res = lsr_ext[WIDTH:1];
                alu_c   = lsr_ext[0];
            end
            default: alu_res = '0;
        endcase
    end

    // Select what gets loaded into the output register and derive its flags
    always_comb begin
        ld_res           = load_mul ? mul_prod : alu_res;
        ld_flags         = '0;
        ld_flags[FLAG_N] = ld_res[WIDTH-1];
        ld_flags[FLAG_Z] = (ld_res == '0);
        ld_flags[FLAG_C] = load_mul ? 1'b0 : alu_c;
        ld_flags[FLAG_V] = load_mul ? 1'b0 : alu_v;
    end

    // Output register: only written on a new result, so a stalled result holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (load_single | load_mul) begin
            result_q <= ld_res;
            flags_q  <= ld_flags;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.Result    = result_q;
    assign bus.ALUFlags  = flags_q;

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        string       nm;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    alu_multicycle_if #(.WIDTH(32)) bus ();

    alu_multicycle #(.WIDTH(32), .MUL_EN(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", nm, got, req);
        end
    endtask

    // Scoreboard monitor: every handshake on the output pops one expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output got=%h required=none", bus.Result);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.nm, "_result"}, bus.Result, e.res);
                    chk({e.nm, "_flags"}, {28'd0, bus.ALUFlags}, {28'd0, e.flg});
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] er, input logic [3:0] ef, input string nm,
                         input bit set_rdy);
        bit ok;
        @(posedge clk); #1;
        bus.in_valid   = 1'b1;
        bus.ALUControl = op;
        bus.a          = av;
        bus.b          = bv;
        if (set_rdy) bus.out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout in_ready=%b required=1", nm, bus.in_ready);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back('{er, ef, nm});
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 32'hDEADBEEF;
        bus.b        = 32'h5A5A5A5A;
        if (op != 3'b111) chk({nm, "_latency1_valid"}, {31'd0, bus.out_valid}, 32'd1);
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) return;
            @(posedge clk);
        end
        checks++;
        failures++;
        $display("FAIL %s_drain_timeout pending=%0d required=0", nm, exp_q.size());
        exp_q.delete();
    endtask

    initial begin
        int  cyc;
        bit  rdy_seen;
        checks         = 0;
        failures       = 0;
        reset_n        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.ALUControl = '0;
        bus.out_ready  = 1'b1;

        #1;
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("reset_result", bus.Result, 32'd0);
        chk("reset_flags", {28'd0, bus.ALUFlags}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Directed single-cycle vectors
        issue(3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, "add_ovf", 1'b0);
        issue(3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110, "sub_eq", 1'b0);
        issue(3'b001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000, "sub_borrow", 1'b0);
        issue(3'b101, 32'h80000001, 32'h00000001, 32'h00000002, 4'b0010, "lsl1", 1'b0);
        issue(3'b110, 32'h00000003, 32'h00000001, 32'h00000001, 4'b0010, "lsr1", 1'b0);
        issue(3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, "add_carry", 1'b0);
        issue(3'b010, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 4'b0100, "and_zero", 1'b0);
        issue(3'b011, 32'h00000000, 32'h80000000, 32'h80000000, 4'b1000, "or_neg", 1'b0);
        issue(3'b101, 32'h00000005, 32'h00000020, 32'h00000005, 4'b0000, "lsl_mod0", 1'b0);
        issue(3'b110, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000, "lsr31", 1'b0);
        wait_drain("single");

        // Multiply: latency and in_ready held low while busy
        issue(3'b111, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0100, "mul_wrap", 1'b0);
        cyc      = 0;
        rdy_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.out_valid) break;
            if (bus.in_ready) rdy_seen = 1'b1;
        end
        chk("mul_latency", cyc, 32'd33);
        chk("mul_busy_in_ready", {31'd0, rdy_seen}, 32'd0);
        issue(3'b111, 32'h0000FFFF, 32'h00000003, 32'h0002FFFD, 4'b0000, "mul_small", 1'b0);
        wait_drain("mul");

        // Output stall, then drain and accept on the same edge
        @(posedge clk); #1 bus.out_ready = 1'b0;
        issue(3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 4'b1000, "xor_hold", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_result", bus.Result, 32'hF0F00F0F);
            chk("hold_flags", {28'd0, bus.ALUFlags}, 32'h8);
            chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        issue(3'b011, 32'h00000001, 32'h00000002, 32'h00000003, 4'b0000, "or_b2b", 1'b1);
        wait_drain("b2b");

        // Reset during a multiply: abandoned, outputs clear without a clock edge
        issue(3'b111, 32'h00001234, 32'h00000010, 32'h00012340, 4'b0000, "mul_abort", 1'b0);
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_result", bus.Result, 32'd0);
        chk("abort_flags", {28'd0, bus.ALUFlags}, 32'd0);
        chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        issue(3'b000, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000, "add_after_rst", 1'b0);
        wait_drain("post_reset");

        repeat (40) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
